// File: rtl/ahb_ic_pkg.sv
// Shared encodings and state type for the AHB-Lite single-manager interconnect.
package ahb_ic_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        OK,
        ERR1,
        ERR2
    } err_state_t;

endpackage

// File: rtl/ahb_lite_interconnect_n_if.sv
// Manager-side and subordinate-side bus signals of the interconnect.
// slave = interconnect view; master = the surrounding manager/subordinate environment.
interface ahb_lite_interconnect_n_if #(
    parameter int NO_OF_SUBORDINATES = 4,
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32
);
    localparam int N = NO_OF_SUBORDINATES;

    logic [ADDR_WIDTH-1:0]   HADDR;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [DATA_WIDTH-1:0]   HRDATA;
    logic [1:0]              HRESP;
    logic                    HREADY;
    logic [N-1:0]            HSEL_S;
    logic                    HREADY_S;
    logic [N*DATA_WIDTH-1:0] HRDATA_S;
    logic [2*N-1:0]          HRESP_S;
    logic [N-1:0]            HREADYOUT_S;
    logic [N-1:0]            lockout;
    logic                    timeout_evt;

    modport slave (
        input  HADDR, HTRANS, HWRITE, HRDATA_S, HRESP_S, HREADYOUT_S,
        output HRDATA, HRESP, HREADY, HSEL_S, HREADY_S, lockout, timeout_evt
    );

    modport master (
        output HADDR, HTRANS, HWRITE, HRDATA_S, HRESP_S, HREADYOUT_S,
        input  HRDATA, HRESP, HREADY, HSEL_S, HREADY_S, lockout, timeout_evt
    );

endinterface

// File: rtl/ahb_lite_interconnect_n_err_fsm.sv
// Two-cycle ERROR response sequencer plus HREADYOUT stall watchdog.
// o_fire is combinational in the last allowed wait cycle; ERR1/ERR2 flags are registered.
module ahb_ic_err_fsm
    import ahb_ic_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_default_hit,
    input  logic i_active,
    input  logic i_tgt_real,
    input  logic i_tgt_readyout,
    input  logic i_hready,
    output logic o_err_override,
    output logic o_err_ready,
    output logic o_fire
);

    localparam int              CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    err_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          w_waiting;

    assign w_waiting = (r_state == OK) && i_tgt_real && i_active && !i_tgt_readyout;
    assign o_fire    = (TIMEOUT_CYCLES > 0) && w_waiting && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= OK;
            r_cnt          <= '0;
            o_err_override <= 1'b0;
            o_err_ready    <= 1'b0;
        end else begin
            case (r_state)
                OK: begin
                    if ((i_hready && i_default_hit) || o_fire) begin
                        r_state        <= ERR1;
                        o_err_override <= 1'b1;
                        o_err_ready    <= 1'b0;
                    end
                end
                ERR1: begin
                    r_state        <= ERR2;
                    o_err_override <= 1'b1;
                    o_err_ready    <= 1'b1;
                end
                ERR2: begin
                    // Back-to-back default accesses chain straight into another ERROR pair.
                    if (i_default_hit) begin
                        r_state        <= ERR1;
                        o_err_override <= 1'b1;
                        o_err_ready    <= 1'b0;
                    end else begin
                        r_state        <= OK;
                        o_err_override <= 1'b0;
                        o_err_ready    <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= OK;
                    o_err_override <= 1'b0;
                    o_err_ready    <= 1'b0;
                end
            endcase

            if (o_fire || i_hready || i_tgt_readyout) begin
                r_cnt <= '0;
            end else if (w_waiting) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ahb_lite_interconnect_n.sv
// AHB-Lite decoder, data-phase response mux and default subordinate with stall lockout.
// Zero added latency on the OKAY path; default/timed-out accesses cost an ERR1/ERR2 pair.
module ahb_lite_interconnect_n
    import ahb_ic_pkg::*;
#(
    parameter int NO_OF_SUBORDINATES    = 4,
    parameter int BITS_FOR_SUBORDINATES = 5,
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int TIMEOUT_CYCLES        = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    ahb_lite_interconnect_n_if.slave  bus
);

    localparam int N  = NO_OF_SUBORDINATES;
    localparam int B  = BITS_FOR_SUBORDINATES;
    localparam int DW = DATA_WIDTH;

    logic [B-1:0]  w_idx;
    logic [N-1:0]  w_hsel;
    logic          w_dec_default;
    logic [N:0]    r_sel;
    logic          r_active;
    logic [N-1:0]  r_lockout;
    logic          r_timeout_evt;
    logic          w_tgt_real;
    logic          w_tgt_readyout;
    logic [DW-1:0] w_tgt_rdata;
    logic [1:0]    w_tgt_resp;
    logic          w_err_override;
    logic          w_err_ready;
    logic          w_fire;
    logic          w_hready;
    logic [1:0]    w_hresp;
    logic [DW-1:0] w_hrdata;
    logic          w_unused;

    assign w_unused = &{1'b0, bus.HWRITE, bus.HTRANS[0], bus.HADDR[ADDR_WIDTH-B-1:0]};

    assign w_idx = bus.HADDR[ADDR_WIDTH-1 -: B];

    always_comb begin
        w_hsel = '0;
        for (int i = 0; i < N; i++) begin
            w_hsel[i] = (w_idx == B'(i)) && !r_lockout[i];
        end
    end

    assign w_dec_default = ~|w_hsel;

    always_comb begin
        w_tgt_readyout = 1'b1;
        w_tgt_rdata    = '0;
        w_tgt_resp     = HRESP_OKAY;
        for (int i = 0; i < N; i++) begin
            if (r_sel[i]) begin
                w_tgt_readyout = bus.HREADYOUT_S[i];
                w_tgt_rdata    = bus.HRDATA_S[i*DW +: DW];
                w_tgt_resp     = bus.HRESP_S[2*i +: 2];
            end
        end
    end

    assign w_tgt_real = ~r_sel[N];

    always_comb begin
        w_hready = 1'b1;
        w_hresp  = HRESP_OKAY;
        w_hrdata = '0;
        if (w_err_override) begin
            w_hready = w_err_ready;
            w_hresp  = HRESP_ERROR;
        end else if (w_tgt_real) begin
            w_hready = w_tgt_readyout;
            w_hresp  = w_tgt_resp;
            w_hrdata = w_tgt_rdata;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sel         <= {1'b1, {N{1'b0}}};
            r_active      <= 1'b0;
            r_lockout     <= '0;
            r_timeout_evt <= 1'b0;
        end else begin
            if (w_hready) begin
                r_sel    <= {w_dec_default, w_hsel};
                r_active <= bus.HTRANS[1];
            end
            if (w_fire) begin
                r_lockout <= r_lockout | r_sel[N-1:0];
            end
            r_timeout_evt <= w_fire;
        end
    end

    ahb_ic_err_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_err_fsm (
        .i_clk          (HCLK),
        .i_rst          (HRESET),
        .i_default_hit  (w_dec_default & bus.HTRANS[1]),
        .i_active       (r_active),
        .i_tgt_real     (w_tgt_real),
        .i_tgt_readyout (w_tgt_readyout),
        .i_hready       (w_hready),
        .o_err_override (w_err_override),
        .o_err_ready    (w_err_ready),
        .o_fire         (w_fire)
    );

    assign bus.HREADY      = w_hready;
    assign bus.HREADY_S    = w_hready;
    assign bus.HRESP       = w_hresp;
    assign bus.HRDATA      = w_hrdata;
    assign bus.HSEL_S      = w_hsel;
    assign bus.lockout     = r_lockout;
    assign bus.timeout_evt = r_timeout_evt;

endmodule

// File: tb/tb_ahb_lite_interconnect_n.sv
// Cycle-table bench for ahb_lite_interconnect_n with N=4 and a 16-cycle watchdog.
module tb_ahb_lite_interconnect_n;
    import ahb_ic_pkg::*;

    localparam int N  = 4;
    localparam int B  = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    localparam logic [1:0] IDL = HTRANS_IDLE;
    localparam logic [1:0] NSQ = HTRANS_NONSEQ;
    localparam logic [1:0] OKY = HRESP_OKAY;
    localparam logic [1:0] ERR = HRESP_ERROR;

    logic HCLK = 1'b0;
    logic HRESET;

    always #5 HCLK = ~HCLK;

    ahb_lite_interconnect_n_if #(
        .NO_OF_SUBORDINATES (N),
        .ADDR_WIDTH         (AW),
        .DATA_WIDTH         (DW)
    ) bus ();

    ahb_lite_interconnect_n #(
        .NO_OF_SUBORDINATES    (N),
        .BITS_FOR_SUBORDINATES (B),
        .ADDR_WIDTH            (AW),
        .DATA_WIDTH            (DW),
        .TIMEOUT_CYCLES        (TO)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [3:0]  rdy;
        logic [7:0]  resp;
        logic [3:0]  x_hsel;
        logic        x_ready;
        logic [1:0]  x_resp;
        logic [31:0] x_data;
        logic [3:0]  x_lock;
        logic        x_evt;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[16];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] sd(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    function automatic vec_t mk(input logic rst, input logic [31:0] addr, input logic [1:0] trans,
                                input logic [3:0] rdy, input logic [7:0] resp, input logic [3:0] hsel,
                                input logic ready, input logic [1:0] xresp, input logic [31:0] data,
                                input logic [3:0] lock, input logic evt);
        vec_t v;
        v.rst = rst;      v.addr = addr;       v.trans = trans;
        v.rdy = rdy;      v.resp = resp;       v.x_hsel = hsel;
        v.x_ready = ready; v.x_resp = xresp;   v.x_data = data;
        v.x_lock = lock;  v.x_evt = evt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        HRESET          = v.rst;
        bus.HADDR       = v.addr;
        bus.HTRANS      = v.trans;
        bus.HREADYOUT_S = v.rdy;
        bus.HRESP_S     = v.resp;
        sb.push_back(v);
        @(negedge HCLK);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            vec_t e;
            e = sb.pop_front();
            chk({tag, ".hsel"},     32'(bus.HSEL_S),      32'(e.x_hsel));
            chk({tag, ".hready"},   32'(bus.HREADY),      32'(e.x_ready));
            chk({tag, ".hready_s"}, 32'(bus.HREADY_S),    32'(e.x_ready));
            chk({tag, ".hresp"},    32'(bus.HRESP),       32'(e.x_resp));
            chk({tag, ".hrdata"},   bus.HRDATA,           e.x_data);
            chk({tag, ".lockout"},  32'(bus.lockout),     32'(e.x_lock));
            chk({tag, ".evt"},      32'(bus.timeout_evt), 32'(e.x_evt));
        end
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rst, addr, trans, rdy, resp | hsel, ready, hresp, hrdata, lockout, evt
        tbl[0]  = mk(0, 32'h0800_0000, NSQ, 4'hF,    8'h00, 4'b0010, 1, OKY, 32'h0,  4'h0, 0);
        tbl[1]  = mk(0, 32'h1000_0000, NSQ, 4'hF,    8'h00, 4'b0100, 1, OKY, sd(1),  4'h0, 0);
        tbl[2]  = mk(0, 32'h1800_0000, NSQ, 4'b1011, 8'h00, 4'b1000, 0, OKY, sd(2),  4'h0, 0);
        tbl[3]  = mk(0, 32'h1800_0000, NSQ, 4'hF,    8'h10, 4'b1000, 1, ERR, sd(2),  4'h0, 0);
        tbl[4]  = mk(0, 32'h2000_0000, NSQ, 4'hF,    8'h00, 4'b0000, 1, OKY, sd(3),  4'h0, 0);
        tbl[5]  = mk(0, 32'h0000_0000, IDL, 4'hF,    8'h00, 4'b0001, 0, ERR, 32'h0,  4'h0, 0);
        tbl[6]  = mk(0, 32'h0000_0000, IDL, 4'hF,    8'h00, 4'b0001, 1, ERR, 32'h0,  4'h0, 0);
        tbl[7]  = mk(0, 32'h2000_0000, IDL, 4'hF,    8'h00, 4'b0000, 1, OKY, sd(0),  4'h0, 0);
        tbl[8]  = mk(0, 32'h0000_0000, IDL, 4'hF,    8'h00, 4'b0001, 1, OKY, 32'h0,  4'h0, 0);
        tbl[9]  = mk(0, 32'h2000_0000, NSQ, 4'hF,    8'h00, 4'b0000, 1, OKY, sd(0),  4'h0, 0);
        tbl[10] = mk(0, 32'h2000_0000, NSQ, 4'hF,    8'h00, 4'b0000, 0, ERR, 32'h0,  4'h0, 0);
        tbl[11] = mk(0, 32'h2000_0000, NSQ, 4'hF,    8'h00, 4'b0000, 1, ERR, 32'h0,  4'h0, 0);
        tbl[12] = mk(0, 32'h0000_0000, IDL, 4'hF,    8'h00, 4'b0001, 0, ERR, 32'h0,  4'h0, 0);
        tbl[13] = mk(0, 32'h0000_0000, IDL, 4'hF,    8'h00, 4'b0001, 1, ERR, 32'h0,  4'h0, 0);
        tbl[14] = mk(0, 32'hF800_0000, IDL, 4'hF,    8'h00, 4'b0000, 1, OKY, sd(0),  4'h0, 0);
        tbl[15] = mk(0, 32'h0000_0000, IDL, 4'hF,    8'h00, 4'b0001, 1, OKY, 32'h0,  4'h0, 0);

        HRESET          = 1'b1;
        bus.HADDR       = '0;
        bus.HTRANS      = IDL;
        bus.HWRITE      = 1'b0;
        bus.HREADYOUT_S = 4'hF;
        bus.HRESP_S     = '0;
        bus.HRDATA_S    = {sd(3), sd(2), sd(1), sd(0)};
        @(posedge HCLK);
        @(posedge HCLK);
        #1;

        step(mk(1, 32'h0, IDL, 4'hF, 8'h00, 4'b0001, 1, OKY, 32'h0, 4'h0, 0), "reset");

        bus.HWRITE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end
        bus.HWRITE = 1'b0;

        // sub2 stalls for the full watchdog window and gets locked out
        step(mk(0, 32'h1000_0000, NSQ, 4'hF, 8'h00, 4'b0100, 1, OKY, sd(0), 4'h0, 0), "to_addr");
        for (int k = 1; k <= TO; k++) begin
            step(mk(0, 32'h0, IDL, 4'b1011, 8'h00, 4'b0001, 0, OKY, sd(2), 4'h0, 0),
                 $sformatf("to_wait%0d", k));
        end
        step(mk(0, 32'h1000_0000, IDL, 4'b1011, 8'h00, 4'b0000, 0, ERR, 32'h0, 4'b0100, 1), "to_err1");
        step(mk(0, 32'h1000_0000, NSQ, 4'b1011, 8'h00, 4'b0000, 1, ERR, 32'h0, 4'b0100, 0), "to_err2");
        step(mk(1, 32'h1000_0000, IDL, 4'hF,    8'h00, 4'b0000, 0, ERR, 32'h0, 4'b0100, 0), "lock_err1_rst");
        step(mk(0, 32'h1000_0000, NSQ, 4'hF,    8'h00, 4'b0100, 1, OKY, 32'h0, 4'h0,    0), "post_rst");

        // sub2 recovers exactly at the threshold cycle: no timeout
        for (int k = 1; k < TO; k++) begin
            step(mk(0, 32'h0, IDL, 4'b1011, 8'h00, 4'b0001, 0, OKY, sd(2), 4'h0, 0),
                 $sformatf("win_wait%0d", k));
        end
        step(mk(0, 32'h0,          IDL, 4'hF, 8'h00, 4'b0001, 1, OKY, sd(2), 4'h0, 0), "win_done");
        step(mk(0, 32'h1000_0000, IDL, 4'hF, 8'h00, 4'b0100, 1, OKY, sd(0), 4'h0, 0), "win_after");
        step(mk(0, 32'h0,          IDL, 4'hF, 8'h00, 4'b0001, 1, OKY, sd(2), 4'h0, 0), "win_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
